monster_march_ctrl: RTL



---
 rtl/space_monsters_pkg.sv | 25 ++
 rtl/march_edge_finder.sv | 28 ++
 rtl/monster_march_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/space_monsters_pkg.sv
// Shared definitions for the monster formation logic: FSM encodings,
// screen limits, monster geometry and colours.
package space_monsters_pkg;

  typedef logic [2:0] march_state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MARCH   = 3'd1;
  localparam logic [2:0] ST_STEP    = 3'd2;
  localparam logic [2:0] ST_HALT    = 3'd3;
  localparam logic [2:0] ST_CLEARED = 3'd4;

  localparam int unsigned SCREEN_X_MIN   = 150;
  localparam int unsigned SCREEN_X_MAX   = 770;
  localparam int unsigned SCREEN_Y_LIMIT = 430;

  localparam int unsigned MONSTER_HALF_W  = 5;
  localparam int unsigned MONSTER_HALF_H  = 3;
  localparam int unsigned MONSTER_SPACING = 100;

  localparam logic [11:0] COLOR_MONSTER = 12'h0F0;
  localparam logic [11:0] COLOR_BG      = 12'h000;
  localparam logic [11:0] COLOR_ALERT   = 12'hF00;

endpackage

// File: rtl/march_edge_finder.sv
// Finds the lowest and highest live slot and the live count of a
// five-slot formation. Purely combinational.
module march_edge_finder (
  input  logic [4:0] alive,
  output logic [2:0] left_idx,
  output logic [2:0] right_idx,
  output logic [2:0] pop,
  output logic       none
);

  always_comb begin
    left_idx  = 3'd0;
    right_idx = 3'd0;
    pop       = 3'd0;
    none      = (alive == 5'd0);
    // Scanning downward leaves the lowest set bit as the final winner.
    for (int i = 4; i >= 0; i--) begin
      if (alive[i]) left_idx = 3'(i);
    end
    for (int i = 0; i < 5; i++) begin
      if (alive[i]) begin
        right_idx = 3'(i);
        pop       = pop + 3'd1;
      end
    end
  end

endmodule

// File: rtl/monster_march_ctrl.sv
// Marches the five-monster formation: frame-counted stepping, edge
// descent with reversal, bottom-breach and cleared-board detection.
module monster_march_ctrl
  import space_monsters_pkg::*;
#(
  parameter int unsigned X_START            = 250,
  parameter int unsigned Y_START            = 100,
  parameter int unsigned SPACING            = MONSTER_SPACING,
  parameter int unsigned HALF_W             = MONSTER_HALF_W,
  parameter int unsigned HALF_H             = MONSTER_HALF_H,
  parameter int unsigned X_MIN              = SCREEN_X_MIN,
  parameter int unsigned X_MAX              = SCREEN_X_MAX,
  parameter int unsigned STEP_X             = 4,
  parameter int unsigned STEP_Y             = 10,
  parameter int unsigned Y_LIMIT            = SCREEN_Y_LIMIT,
  parameter int unsigned FRAMES_PER_MONSTER = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pause,
  input  logic         frame_tick,
  input  logic [4:0]   alive,
  output logic [9:0]   xpos_base,
  output logic [9:0]   ypos_base,
  output logic         dir_right,
  output logic         busy,
  output logic         step_strobe,
  output logic         reached_bottom,
  output logic         cleared,
  output march_state_t state
);

  logic [2:0]  left_idx;
  logic [2:0]  right_idx;
  logic [2:0]  pop;
  logic        none;
  logic [7:0]  cnt;
  logic [7:0]  period;
  logic [7:0]  pop_period;
  logic        wrap_q;
  logic [10:0] right_edge;
  logic [10:0] left_edge;
  logic        hit_right;
  logic        hit_left;
  logic        hits_bottom;

  march_edge_finder u_edge (
    .alive     (alive),
    .left_idx  (left_idx),
    .right_idx (right_idx),
    .pop       (pop),
    .none      (none)
  );

  assign pop_period = 8'(pop) * 8'(FRAMES_PER_MONSTER);

  // 11-bit intermediates keep the edge tests free of wrap-around.
  assign right_edge  = 11'(xpos_base) + 11'(right_idx) * 11'(SPACING)
                     + 11'(HALF_W) + 11'(STEP_X);
  assign left_edge   = 11'(xpos_base) + 11'(left_idx) * 11'(SPACING);
  assign hit_right   = right_edge > 11'(X_MAX);
  assign hit_left    = left_edge < 11'(X_MIN + HALF_W + STEP_X);
  assign hits_bottom = (11'(ypos_base) + 11'(STEP_Y) + 11'(HALF_H)) >= 11'(Y_LIMIT);

  assign busy = (state == ST_MARCH) || (state == ST_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      xpos_base      <= 10'(X_START);
      ypos_base      <= 10'(Y_START);
      dir_right      <= 1'b1;
      cnt            <= 8'd0;
      period         <= 8'd0;
      wrap_q         <= 1'b0;
      step_strobe    <= 1'b0;
      reached_bottom <= 1'b0;
      cleared        <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      if (start) begin
        state          <= ST_MARCH;
        xpos_base      <= 10'(X_START);
        ypos_base      <= 10'(Y_START);
        dir_right      <= 1'b1;
        cnt            <= 8'd0;
        period         <= pop_period;
        wrap_q         <= 1'b0;
        reached_bottom <= 1'b0;
        cleared        <= 1'b0;
      end else begin
        case (state)
          ST_MARCH: begin
            if (none) begin
              state   <= ST_CLEARED;
              cleared <= 1'b1;
              wrap_q  <= 1'b0;
            end else if (!pause) begin
              // A wrap registers first; STEP follows one cycle later.
              if (wrap_q) begin
                wrap_q <= 1'b0;
                state  <= ST_STEP;
              end
              if (frame_tick) begin
                if (cnt == period - 8'd1) begin
                  cnt    <= 8'd0;
                  wrap_q <= 1'b1;
                  period <= pop_period;
                end else begin
                  cnt <= cnt + 8'd1;
                end
              end
            end
          end
          ST_STEP: begin
            if (none) begin
              state   <= ST_CLEARED;
              cleared <= 1'b1;
            end else begin
              step_strobe <= 1'b1;
              state       <= ST_MARCH;
              if ((dir_right && hit_right) || (!dir_right && hit_left)) begin
                ypos_base <= ypos_base + 10'(STEP_Y);
                dir_right <= ~dir_right;
                if (hits_bottom) begin
                  state          <= ST_HALT;
                  reached_bottom <= 1'b1;
                end
              end else if (dir_right) begin
                xpos_base <= xpos_base + 10'(STEP_X);
              end else begin
                xpos_base <= xpos_base - 10'(STEP_X);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
